// File: rtl/ex_mem_if.sv
// ID/EX -> EX/MEM -> MEM handshake bundle: operands/controls in, registered MEM entry out.
interface ex_mem_if #(
   parameter int XLEN = 64
);
   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_final_a;
   logic [XLEN-1:0] ex_final_b;
   logic [2:0]      ex_alu_op;
   logic            ex_sub;
   logic            ex_slt_and_spin_off_signed;
   logic            ex_slt_and_spin_off_unsigned;
   logic            ex_word_op;
   logic            ex_is_write_dmem;
   logic [1:0]      ex_wb_select;
   logic [7:0]      ex_write_width;
   logic [XLEN-1:0] ex_dmem_write_data;
   logic            mem_ready;
   logic            mem_valid;
   logic [XLEN-1:0] mem_alu_result;
   logic            mem_is_write_dmem;
   logic [1:0]      mem_wb_select;
   logic [7:0]      mem_write_width;
   logic [XLEN-1:0] mem_dmem_write_data;

   modport master (
      output ex_valid, ex_final_a, ex_final_b, ex_alu_op, ex_sub,
             ex_slt_and_spin_off_signed, ex_slt_and_spin_off_unsigned, ex_word_op,
             ex_is_write_dmem, ex_wb_select, ex_write_width, ex_dmem_write_data, mem_ready,
      input  ex_ready, mem_valid, mem_alu_result, mem_is_write_dmem, mem_wb_select,
             mem_write_width, mem_dmem_write_data
   );

   modport slave (
      input  ex_valid, ex_final_a, ex_final_b, ex_alu_op, ex_sub,
             ex_slt_and_spin_off_signed, ex_slt_and_spin_off_unsigned, ex_word_op,
             ex_is_write_dmem, ex_wb_select, ex_write_width, ex_dmem_write_data, mem_ready,
      output ex_ready, mem_valid, mem_alu_result, mem_is_write_dmem, mem_wb_select,
             mem_write_width, mem_dmem_write_data
   );
endinterface

// File: rtl/ex_mem.sv
// RV64I execute stage (incl. W-ops) plus a one-entry EX/MEM register with valid/ready,
// flush, and a saturating back-pressure cycle counter.
module ex_mem #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   ex_mem_if.slave          bus,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [XLEN-1:0]        a, b, alu_full, alu_res, sra_full;
   logic [31:0]            a_w, alu_w, sra_w;
   logic                   lt_s, lt_u, word_ok;

   logic                   valid_q, valid_d;
   logic [XLEN-1:0]        res_q, res_d;
   logic                   wr_q, wr_d;
   logic [1:0]             wb_q, wb_d;
   logic [7:0]             ww_q, ww_d;
   logic [XLEN-1:0]        wd_q, wd_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ready, load, stalled;

   // Signed shifts live in their own assignments so the surrounding context cannot
   // turn them into logical shifts.
   always_comb begin
      a        = bus.ex_final_a;
      b        = bus.ex_final_b;
      a_w      = a[31:0];
      lt_s     = $signed(a) < $signed(b);
      lt_u     = a < b;
      sra_full = $signed(a) >>> b[5:0];
      sra_w    = $signed(a_w) >>> b[4:0];

      alu_full = '0;
      case (bus.ex_alu_op)
         3'b000:  alu_full = bus.ex_sub ? a - b : a + b;
         3'b001:  alu_full = a << b[5:0];
         3'b010:  alu_full = {{(XLEN-1){1'b0}}, lt_s};
         3'b011:  alu_full = {{(XLEN-1){1'b0}}, lt_u};
         3'b100:  alu_full = a ^ b;
         3'b101:  alu_full = bus.ex_sub ? sra_full : a >> b[5:0];
         3'b110:  alu_full = a | b;
         default: alu_full = a & b;
      endcase

      alu_w   = '0;
      word_ok = 1'b1;
      case (bus.ex_alu_op)
         3'b000:  alu_w = bus.ex_sub ? a_w - b[31:0] : a_w + b[31:0];
         3'b001:  alu_w = a_w << b[4:0];
         3'b101:  alu_w = bus.ex_sub ? sra_w : a_w >> b[4:0];
         default: word_ok = 1'b0;
      endcase

      if (bus.ex_slt_and_spin_off_signed)
         alu_res = {{(XLEN-1){1'b0}}, lt_s};
      else if (bus.ex_slt_and_spin_off_unsigned)
         alu_res = {{(XLEN-1){1'b0}}, lt_u};
      else if (bus.ex_word_op && word_ok)
         alu_res = {{(XLEN-32){alu_w[31]}}, alu_w};
      else
         alu_res = alu_full;
   end

   always_comb begin
      ready   = !valid_q || bus.mem_ready;
      load    = bus.ex_valid && ready && !flush;
      stalled = valid_q && !bus.mem_ready;

      valid_d = 1'b0;
      if (!flush)
         valid_d = load || stalled;

      res_d = res_q;
      wr_d  = wr_q;
      wb_d  = wb_q;
      ww_d  = ww_q;
      wd_d  = wd_q;
      if (load) begin
         res_d = alu_res;
         wr_d  = bus.ex_is_write_dmem;
         wb_d  = bus.ex_wb_select;
         ww_d  = bus.ex_write_width;
         wd_d  = bus.ex_dmem_write_data;
      end

      cnt_d = cnt_q;
      if (stalled && cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         valid_q <= 1'b0;
         res_q   <= '0;
         wr_q    <= 1'b0;
         wb_q    <= '0;
         ww_q    <= '0;
         wd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         res_q   <= res_d;
         wr_q    <= wr_d;
         wb_q    <= wb_d;
         ww_q    <= ww_d;
         wd_q    <= wd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ex_ready            = ready;
   assign bus.mem_valid           = valid_q;
   assign bus.mem_alu_result      = res_q;
   assign bus.mem_is_write_dmem   = wr_q;
   assign bus.mem_wb_select       = wb_q;
   assign bus.mem_write_width     = ww_q;
   assign bus.mem_dmem_write_data = wd_q;
   assign stall_cnt               = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: expected MEM entries are queued as instructions are
// accepted and compared when the DUT presents them.
module tb_ex_mem;
   localparam int XLEN  = 64;
   localparam int CNT_W = 32;

   logic             sys_clk = 1'b0;
   logic             sys_rst;
   logic             flush;
   logic [CNT_W-1:0] stall_cnt;

   ex_mem_if #(.XLEN(XLEN)) bus ();

   ex_mem #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .bus       (bus),
      .flush     (flush),
      .stall_cnt (stall_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [63:0] res;
      logic        wr;
      logic [1:0]  wb;
      logic [7:0]  ww;
      logic [63:0] wd;
   } exp_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  op;
      logic        sub;
      logic        ss;
      logic        su;
      logic        word;
      logic [63:0] res;
   } vec_t;

   exp_t        sb[$];
   int unsigned total = 0;
   int unsigned bad   = 0;

   function automatic exp_t observed();
      return '{bus.mem_alu_result, bus.mem_is_write_dmem, bus.mem_wb_select,
               bus.mem_write_width, bus.mem_dmem_write_data};
   endfunction

   // Reference ALU, written from the instruction semantics.
   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] op, input logic sub,
                                         input logic ss, input logic su, input logic word);
      logic signed [63:0] sa, sbv;
      logic signed [31:0] sw;
      logic [31:0]        w;
      sa  = a;
      sbv = b;
      if (ss) return (sa < sbv) ? 64'd1 : 64'd0;
      if (su) return (a < b) ? 64'd1 : 64'd0;
      if (word && (op == 3'd0 || op == 3'd1 || op == 3'd5)) begin
         if (op == 3'd0)      w = sub ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
         else if (op == 3'd1) w = a[31:0] << b[4:0];
         else if (!sub)       w = a[31:0] >> b[4:0];
         else begin
            sw = a[31:0];
            sw = sw >>> b[4:0];
            w  = sw;
         end
         return {{32{w[31]}}, w};
      end
      case (op)
         3'd0: return sub ? a - b : a + b;
         3'd1: return a << b[5:0];
         3'd2: return (sa < sbv) ? 64'd1 : 64'd0;
         3'd3: return (a < b) ? 64'd1 : 64'd0;
         3'd4: return a ^ b;
         3'd5: begin
            if (sub) begin
               sa = sa >>> b[5:0];
               return sa;
            end
            return a >> b[5:0];
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic drive(input vec_t v, input bit push);
      exp_t e;
      bus.ex_valid                     = 1'b1;
      bus.ex_final_a                   = v.a;
      bus.ex_final_b                   = v.b;
      bus.ex_alu_op                    = v.op;
      bus.ex_sub                       = v.sub;
      bus.ex_slt_and_spin_off_signed   = v.ss;
      bus.ex_slt_and_spin_off_unsigned = v.su;
      bus.ex_word_op                   = v.word;
      bus.ex_is_write_dmem             = 1'($urandom);
      bus.ex_wb_select                 = 2'($urandom);
      bus.ex_write_width               = 8'($urandom);
      bus.ex_dmem_write_data           = {$urandom, $urandom};
      e = '{v.res, bus.ex_is_write_dmem, bus.ex_wb_select, bus.ex_write_width,
            bus.ex_dmem_write_data};
      if (push) sb.push_back(e);
   endtask

   task automatic do_reset();
      sys_rst       = 1'b1;
      flush         = 1'b0;
      bus.ex_valid  = 1'b0;
      bus.mem_ready = 1'b1;
      bus.ex_final_a = '0;
      bus.ex_final_b = '0;
      bus.ex_alu_op  = '0;
      bus.ex_sub     = 1'b0;
      bus.ex_slt_and_spin_off_signed   = 1'b0;
      bus.ex_slt_and_spin_off_unsigned = 1'b0;
      bus.ex_word_op           = 1'b0;
      bus.ex_is_write_dmem     = 1'b0;
      bus.ex_wb_select         = '0;
      bus.ex_write_width       = '0;
      bus.ex_dmem_write_data   = '0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if (bus.mem_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid: got %b want 0", bus.mem_valid);
      end
      total++;
      if (observed() !== exp_t'('0)) begin
         bad++; $display("FAIL reset_data: got %h want 0", observed());
      end
      total++;
      if (stall_cnt !== '0) begin
         bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      end
      total++;
      if (bus.ex_ready !== 1'b1) begin
         bad++; $display("FAIL reset_ready: got %b want 1", bus.ex_ready);
      end
   endtask

   task automatic test_alu();
      vec_t tbl[16];
      exp_t e;
      tbl[0]  = '{64'd5, 64'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 64'd2};
      tbl[1]  = '{64'h0000_0000_7FFF_FFFF, 64'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000};
      tbl[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'd1};
      tbl[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
      tbl[4]  = '{64'h0000_0000_8000_0000, 64'd4, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_F800_0000};
      tbl[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 64'd1};
      tbl[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
      tbl[7]  = '{64'd1, 64'h43, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8};
      tbl[8]  = '{64'h8000_0000_0000_0000, 64'd63, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1};
      tbl[9]  = '{64'h8000_0000_0000_0000, 64'd63, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[10] = '{64'hFFFF_FFFF_8000_0000, 64'd4, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0800_0000};
      tbl[11] = '{64'd1, 64'h3F, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000};
      tbl[12] = '{64'hF0F0_0000_0000_00FF, 64'hFF, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 64'hF0F0_0000_0000_0000};
      tbl[13] = '{64'hA, 64'h5, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 64'hF};
      tbl[14] = '{64'hC, 64'hA, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8};
      tbl[15] = '{64'd0, 64'd1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
      do_reset();
      for (int i = 0; i < 16; i++) begin
         @(negedge sys_clk);
         bus.mem_ready = 1'b1;
         drive(tbl[i], 1'b1);
         @(posedge sys_clk);
         #1;
         total++;
         if (bus.mem_valid !== 1'b1) begin
            bad++; $display("FAIL alu_valid[%0d]: got %b want 1", i, bus.mem_valid);
         end
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL alu_sb[%0d]: got empty want entry", i);
         end else begin
            e = sb.pop_front();
            if (observed() !== e) begin
               bad++; $display("FAIL alu_entry[%0d]: got %h want %h", i, observed(), e);
            end
         end
      end
      bus.ex_valid = 1'b0;
   endtask

   task automatic test_stall();
      exp_t held;
      vec_t v;
      do_reset();
      @(negedge sys_clk);
      drive('{64'd100, 64'd23, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd123}, 1'b1);
      @(posedge sys_clk);
      #1;
      held = sb.pop_front();
      total++;
      if (bus.mem_valid !== 1'b1 || observed() !== held) begin
         bad++; $display("FAIL stall_load: got %b/%h want 1/%h", bus.mem_valid, observed(), held);
      end
      @(negedge sys_clk);
      bus.mem_ready = 1'b0;
      v = '{64'd7, 64'd9, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd16};
      drive(v, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge sys_clk);
         #1;
         total++;
         if (bus.mem_valid !== 1'b1 || observed() !== held) begin
            bad++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/%h", i, bus.mem_valid, observed(), held);
         end
         total++;
         if (bus.ex_ready !== 1'b0) begin
            bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.ex_ready);
         end
         total++;
         if (stall_cnt !== CNT_W'(i)) begin
            bad++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, stall_cnt, i);
         end
      end
      @(negedge sys_clk);
      bus.ex_valid  = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if (bus.ex_ready !== 1'b1) begin
         bad++; $display("FAIL release_ready: got %b want 1", bus.ex_ready);
      end
      @(posedge sys_clk);
      #1;
      total++;
      if (bus.mem_valid !== 1'b0 || bus.mem_alu_result !== held.res) begin
         bad++; $display("FAIL drain: got %b/%h want 0/%h", bus.mem_valid, bus.mem_alu_result, held.res);
      end
      total++;
      if (stall_cnt !== CNT_W'(3)) begin
         bad++; $display("FAIL drain_cnt: got %0d want 3", stall_cnt);
      end
   endtask

   task automatic test_flush();
      exp_t held;
      do_reset();
      @(negedge sys_clk);
      drive('{64'h55, 64'h0F, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 64'h05}, 1'b1);
      @(posedge sys_clk);
      #1;
      held = sb.pop_front();
      total++;
      if (bus.mem_valid !== 1'b1 || observed() !== held) begin
         bad++; $display("FAIL flush_load: got %b/%h want 1/%h", bus.mem_valid, observed(), held);
      end
      @(negedge sys_clk);
      flush = 1'b1;
      drive('{64'h1, 64'h1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h2}, 1'b0);
      @(posedge sys_clk);
      #1;
      total++;
      if (bus.mem_valid !== 1'b0 || observed() !== held) begin
         bad++; $display("FAIL flush_held: got %b/%h want 0/%h", bus.mem_valid, observed(), held);
      end
      @(negedge sys_clk);
      bus.mem_ready = 1'b0;
      @(posedge sys_clk);
      #1;
      total++;
      if (bus.mem_valid !== 1'b0 || observed() !== held) begin
         bad++; $display("FAIL flush_empty: got %b/%h want 0/%h", bus.mem_valid, observed(), held);
      end
      @(negedge sys_clk);
      flush         = 1'b0;
      bus.ex_valid  = 1'b0;
      bus.mem_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [2:0]   ops[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      logic         tv, mr, take, acc;
      logic [CNT_W-1:0] cnt;
      exp_t         last, e;
      vec_t         v;
      int unsigned  r;
      do_reset();
      tv   = 1'b0;
      cnt  = '0;
      last = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clk);
         mr   = ($urandom_range(0, 2) != 0);
         take = ($urandom_range(0, 3) != 0);
         acc  = take && (!tv || mr);
         bus.mem_ready = mr;
         if (take) begin
            r      = $urandom_range(0, 9);
            v.a    = {$urandom, $urandom};
            v.b    = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom};
            v.op   = ops[$urandom_range(0, 5)];
            v.sub  = 1'($urandom);
            v.ss   = (r == 0);
            v.su   = (r == 1);
            v.word = 1'($urandom);
            v.res  = model(v.a, v.b, v.op, v.sub, v.ss, v.su, v.word);
            drive(v, acc);
         end else begin
            bus.ex_valid = 1'b0;
         end
         #1;
         total++;
         if (bus.ex_ready !== (!tv || mr)) begin
            bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, bus.ex_ready, !tv || mr);
         end
         @(posedge sys_clk);
         #1;
         if (tv && !mr && cnt != '1) cnt++;
         if (acc) begin
            tv = 1'b1;
            if (sb.size() != 0) last = sb.pop_front();
         end else if (!(tv && !mr)) begin
            tv = 1'b0;
         end
         total++;
         if (bus.mem_valid !== tv) begin
            bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, bus.mem_valid, tv);
         end
         e = observed();
         if (tv) begin
            total++;
            if (e !== last) begin
               bad++; $display("FAIL b2b_entry[%0d]: got %h want %h", i, e, last);
            end
         end
         total++;
         if (stall_cnt !== cnt) begin
            bad++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, stall_cnt, cnt);
         end
      end
      bus.ex_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      @(negedge sys_clk);
      drive('{64'd40, 64'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd42}, 1'b1);
      @(negedge sys_clk);
      bus.ex_valid  = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      total++;
      if (bus.mem_valid !== 1'b1 || stall_cnt !== CNT_W'(2)) begin
         bad++; $display("FAIL pre_rst: got %b/%0d want 1/2", bus.mem_valid, stall_cnt);
      end
      #2;
      sys_rst = 1'b1;
      #1;
      total++;
      if (bus.mem_valid !== 1'b0 || stall_cnt !== '0 || observed() !== exp_t'('0)) begin
         bad++; $display("FAIL async_rst: got %b/%0d/%h want 0/0/0", bus.mem_valid, stall_cnt, observed());
      end
      total++;
      if (bus.ex_ready !== 1'b1) begin
         bad++; $display("FAIL async_rst_ready: got %b want 1", bus.ex_ready);
      end
      @(negedge sys_clk);
      sys_rst       = 1'b0;
      bus.mem_ready = 1'b1;
      sb.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want test completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_alu();
      test_stall();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
